sram_port_arbiter: RTL and testbench

- Shares one single-read/single-write-port, word-masked SRAM between NUM_REQ requesters using round-robin arbitration.
- Issues at most one read or one masked write per cycle.
- Returns read data to the winning requester one cycle after grant.
- Owns memory initialisation: after reset, or on request, it clears every row before any requester is served.

---
 rtl/sram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one word-masked 1R1W SRAM among NUM_REQ requesters.
// Clears every row after reset or on init_start before any requester is served.
module sram_port_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WIDTH        = 512,
   parameter int LOG_NUM_ROWS = 9,
   parameter int WORD_SIZE    = 64,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0,
   localparam int NUM_WORDS   = WIDTH / WORD_SIZE
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              init_start,
   output logic                              init_done,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0]                req_write,
   input  logic [NUM_REQ*LOG_NUM_ROWS-1:0]   req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]          req_wdata,
   input  logic [NUM_REQ*NUM_WORDS-1:0]      req_wmask,
   output logic [NUM_REQ-1:0]                rsp_valid,
   output logic [WIDTH-1:0]                  rsp_data,
   output logic [LOG_NUM_ROWS-1:0]           sram_read_addr,
   input  logic [WIDTH-1:0]                  sram_read_data,
   output logic [LOG_NUM_ROWS-1:0]           sram_write_addr,
   output logic [WIDTH-1:0]                  sram_write_data,
   output logic [NUM_WORDS-1:0]              sram_write_en
);

   localparam int NUM_ROWS = 2 ** LOG_NUM_ROWS;
   localparam int PTR_W    = $clog2(NUM_REQ);

   typedef enum logic {INIT, RUN} arbState_t;

   arbState_t               stateReg, stateNext;
   logic [LOG_NUM_ROWS-1:0] initCntReg, initCntNext;
   logic [PTR_W-1:0]        rrPtrReg, rrPtrNext;
   logic [NUM_REQ-1:0]      rspValidReg, rspValidNext;
   logic [LOG_NUM_ROWS-1:0] readAddrReg, readAddrNext;

   logic [LOG_NUM_ROWS-1:0] reqAddrArr  [NUM_REQ];
   logic [WIDTH-1:0]        reqWdataArr [NUM_REQ];
   logic [NUM_WORDS-1:0]    reqWmaskArr [NUM_REQ];

   logic             grantFound;
   logic [PTR_W-1:0] grantIdx;
   logic             grantValid;
   logic             grantWrite;
   logic             grantRead;
   logic [NUM_REQ-1:0] grantOneHot;
   logic [NUM_WORDS-1:0] writeEnRaw;
   int               searchIdx;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign reqAddrArr[gi]  = req_addr[gi*LOG_NUM_ROWS +: LOG_NUM_ROWS];
      assign reqWdataArr[gi] = req_wdata[gi*WIDTH +: WIDTH];
      assign reqWmaskArr[gi] = req_wmask[gi*NUM_WORDS +: NUM_WORDS];
   end

   // First valid requester at or after rrPtrReg, wrapping around.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      searchIdx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         searchIdx = int'(rrPtrReg) + k;
         if (searchIdx >= NUM_REQ) searchIdx = searchIdx - NUM_REQ;
         if (!grantFound && req_valid[searchIdx]) begin
            grantFound = 1'b1;
            grantIdx   = PTR_W'(searchIdx);
         end
      end
   end

   assign grantValid  = (stateReg == RUN) && !init_start && grantFound;
   assign grantWrite  = grantValid && req_write[grantIdx];
   assign grantRead   = grantValid && !req_write[grantIdx];
   assign grantOneHot = grantValid ? (NUM_REQ'(1) << grantIdx) : '0;
   assign req_ready   = grantOneHot;

   always_comb begin
      stateNext    = stateReg;
      initCntNext  = initCntReg;
      rrPtrNext    = rrPtrReg;
      rspValidNext = '0;
      readAddrNext = readAddrReg;
      case (stateReg)
         INIT: begin
            initCntNext = initCntReg + 1'b1;
            if (initCntReg == LOG_NUM_ROWS'(NUM_ROWS - 1)) stateNext = RUN;
         end
         RUN: begin
            if (init_start) begin
               stateNext   = INIT;
               initCntNext = '0;
            end else if (grantValid) begin
               rrPtrNext = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
               if (grantRead) begin
                  rspValidNext = grantOneHot;
                  readAddrNext = reqAddrArr[grantIdx];
               end
            end
         end
         default: stateNext = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg    <= INIT;
         initCntReg  <= '0;
         rrPtrReg    <= '0;
         rspValidReg <= '0;
         readAddrReg <= '0;
      end else begin
         stateReg    <= stateNext;
         initCntReg  <= initCntNext;
         rrPtrReg    <= rrPtrNext;
         rspValidReg <= rspValidNext;
         readAddrReg <= readAddrNext;
      end
   end

   always_comb begin
      sram_write_addr = '0;
      sram_write_data = '0;
      writeEnRaw      = '0;
      if (stateReg == INIT) begin
         sram_write_addr = initCntReg;
         sram_write_data = INIT_VALUE;
         writeEnRaw      = '1;
      end else if (grantWrite) begin
         sram_write_addr = reqAddrArr[grantIdx];
         sram_write_data = reqWdataArr[grantIdx];
         writeEnRaw      = reqWmaskArr[grantIdx];
      end
   end

   // The init sweep must not touch the SRAM while reset is still asserted.
   assign sram_write_en  = writeEnRaw & {NUM_WORDS{reset}};
   assign sram_read_addr = grantRead ? reqAddrArr[grantIdx] : readAddrReg;
   assign init_done      = (stateReg == RUN);
   assign rsp_valid      = rspValidReg;
   assign rsp_data       = sram_read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized self-checking bench for sram_port_arbiter with a behavioural SRAM,
// an array-based memory model and an integer round-robin model.
module tb_sram_port_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 512;
   localparam int LOG       = 4;
   localparam int WS        = 64;
   localparam int NW        = WIDTH / WS;
   localparam int NUM_ROWS  = 16;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     init_start = 1'b0;
   logic                     init_done;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       req_write = '0;
   logic [NUM_REQ*LOG-1:0]   req_addr = '0;
   logic [NUM_REQ*WIDTH-1:0] req_wdata = '0;
   logic [NUM_REQ*NW-1:0]    req_wmask = '0;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]         rsp_data;
   logic [LOG-1:0]           sram_read_addr;
   logic [WIDTH-1:0]         sram_read_data;
   logic [LOG-1:0]           sram_write_addr;
   logic [WIDTH-1:0]         sram_write_data;
   logic [NW-1:0]            sram_write_en;

   int testsRun = 0;
   int testsFailed = 0;

   sram_port_arbiter #(
      .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LOG_NUM_ROWS(LOG), .WORD_SIZE(WS), .INIT_VALUE('0)
   ) dut (
      .clk(clk), .reset(reset), .init_start(init_start), .init_done(init_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data),
      .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
      .sram_write_en(sram_write_en)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: word-masked write, registered read.
   logic [WIDTH-1:0] sramMem [NUM_ROWS];
   always @(posedge clk) begin
      for (int w = 0; w < NW; w++)
         if (sram_write_en[w]) sramMem[sram_write_addr][w*WS +: WS] <= sram_write_data[w*WS +: WS];
      sram_read_data <= sramMem[sram_read_addr];
   end

   // Reference model state
   logic [WIDTH-1:0] refMem [NUM_ROWS];
   int               refRr;
   logic [NUM_REQ-1:0] pendRsp;
   logic [WIDTH-1:0] pendData;
   logic [LOG-1:0]   refRaddr;

   // Staged per-requester request fields, applied by step() after the edge
   logic [LOG-1:0]   stAddr [NUM_REQ];
   logic [WIDTH-1:0] stData [NUM_REQ];
   logic [NW-1:0]    stMask [NUM_REQ];

   // Expectations for the cycle just driven
   int               expGrant;
   logic [NUM_REQ-1:0] expReady, expRsp;
   logic [WIDTH-1:0] expRspData, expWdata;
   logic [LOG-1:0]   expAddr;
   logic [NW-1:0]    expWen;
   bit               expIsWrite;

   task automatic model_clear();
      for (int r = 0; r < NUM_ROWS; r++) refMem[r] = '0;
      pendRsp = '0;
   endtask

   task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] w, input logic ist);
      @(posedge clk); #1;
      req_valid = v; req_write = w; init_start = ist;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*LOG +: LOG]     = stAddr[i];
         req_wdata[i*WIDTH +: WIDTH] = stData[i];
         req_wmask[i*NW +: NW]      = stMask[i];
      end
      expRsp = pendRsp; expRspData = pendData;
      expGrant = -1;
      if (!ist)
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (refRr + k) % NUM_REQ;
            if (expGrant < 0 && v[idx]) expGrant = idx;
         end
      expReady = (expGrant >= 0) ? NUM_REQ'(1 << expGrant) : '0;
      pendRsp = '0; expIsWrite = 1'b0; expWen = '0;
      if (expGrant >= 0) begin
         refRr = (expGrant + 1) % NUM_REQ;
         expAddr = stAddr[expGrant];
         if (w[expGrant]) begin
            expIsWrite = 1'b1; expWen = stMask[expGrant]; expWdata = stData[expGrant];
            for (int wd = 0; wd < NW; wd++)
               if (expWen[wd]) refMem[expAddr][wd*WS +: WS] = expWdata[wd*WS +: WS];
            $display("[TB] t=%0t write req=%0d addr=%0d mask=%h", $time, expGrant, expAddr, expWen);
         end else begin
            pendRsp = expReady; pendData = refMem[expAddr]; refRaddr = expAddr;
            $display("[TB] t=%0t read  req=%0d addr=%0d", $time, expGrant, expAddr);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      testsRun++; if (init_done !== 1'b0) begin testsFailed++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
      testsRun++; if (req_ready !== '0) begin testsFailed++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      testsRun++; if (rsp_valid !== '0) begin testsFailed++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      testsRun++; if (sram_write_en !== '0) begin testsFailed++; $display("FAIL reset_wen got=%h exp=0", sram_write_en); end
      testsRun++; if (sram_read_addr !== '0 || sram_write_addr !== '0) begin testsFailed++; $display("FAIL reset_addr rd=%0d wr=%0d exp=0", sram_read_addr, sram_write_addr); end
      @(posedge clk); #1;
      reset = 1'b1; req_valid = '1;
      for (int i = 0; i < NUM_ROWS; i++) begin
         @(negedge clk);
         testsRun++;
         if (sram_write_en !== '1 || sram_write_addr !== LOG'(i) || sram_write_data !== '0) begin
            testsFailed++; $display("FAIL init_sweep row=%0d got wen=%h addr=%0d exp wen=ff addr=%0d", i, sram_write_en, sram_write_addr, i);
         end
         testsRun++; if (req_ready !== '0 || init_done !== 1'b0) begin testsFailed++; $display("FAIL init_ready cyc=%0d ready=%b done=%b exp 0/0", i, req_ready, init_done); end
         if (i == NUM_ROWS - 1) req_valid = '0;
      end
      @(negedge clk);
      testsRun++; if (init_done !== 1'b1) begin testsFailed++; $display("FAIL init_done_rise got=%b exp=1", init_done); end
      model_clear(); refRr = 0; refRaddr = '0;
   endtask

   task automatic test_roundtrip();
      logic [WIDTH-1:0] pat;
      pat = {NW{64'hA5}};
      stAddr[2] = 4'd5; stData[2] = pat; stMask[2] = 8'hFF;
      step(4'b0100, 4'b0100, 1'b0);
      testsRun++; if (req_ready !== 4'b0100) begin testsFailed++; $display("FAIL rt_wr_ready got=%b exp=0100", req_ready); end
      testsRun++; if (sram_write_en !== 8'hFF || sram_write_addr !== 4'd5 || sram_write_data !== pat) begin testsFailed++; $display("FAIL rt_wr_port wen=%h addr=%0d exp ff/5", sram_write_en, sram_write_addr); end
      step(4'b0100, 4'b0000, 1'b0);
      testsRun++; if (req_ready !== 4'b0100 || sram_read_addr !== 4'd5 || sram_write_en !== '0) begin testsFailed++; $display("FAIL rt_rd_port ready=%b raddr=%0d wen=%h exp 0100/5/0", req_ready, sram_read_addr, sram_write_en); end
      step('0, '0, 1'b0);
      testsRun++; if (rsp_valid !== 4'b0100) begin testsFailed++; $display("FAIL rt_rsp_valid got=%b exp=0100", rsp_valid); end
      testsRun++; if (rsp_data !== pat) begin testsFailed++; $display("FAIL rt_rsp_data got=%h exp=%h", rsp_data, pat); end
   endtask

   task automatic test_partial_mask();
      logic [WIDTH-1:0] expv;
      expv = '0; expv[63:0] = '1;
      stAddr[0] = 4'd3; stData[0] = '1; stMask[0] = 8'h01;
      step(4'b0001, 4'b0001, 1'b0);
      testsRun++; if (sram_write_en !== 8'h01) begin testsFailed++; $display("FAIL pm_wen got=%h exp=01", sram_write_en); end
      step(4'b0001, 4'b0000, 1'b0);
      step('0, '0, 1'b0);
      testsRun++; if (rsp_valid !== 4'b0001 || rsp_data !== expv) begin testsFailed++; $display("FAIL pm_rsp valid=%b data=%h exp 0001/%h", rsp_valid, rsp_data, expv); end
   endtask

   task automatic test_round_robin();
      stAddr[3] = 4'($urandom_range(0, 15));
      step(4'b1000, 4'b0000, 1'b0);           // leaves the pointer at requester 0
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < NUM_REQ; r++) stAddr[r] = 4'($urandom_range(0, 15));
         step(4'b1111, 4'b0000, 1'b0);
         testsRun++; if (req_ready !== NUM_REQ'(1 << (i % 4))) begin testsFailed++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, req_ready, NUM_REQ'(1 << (i % 4))); end
         testsRun++; if (rsp_valid !== NUM_REQ'(1 << ((i + 3) % 4)) || rsp_data !== expRspData) begin testsFailed++; $display("FAIL rr_rsp i=%0d got=%b exp=%b", i, rsp_valid, NUM_REQ'(1 << ((i + 3) % 4))); end
      end
      step('0, '0, 1'b0);
      testsRun++; if (rsp_valid !== 4'b1000) begin testsFailed++; $display("FAIL rr_last_rsp got=%b exp=1000", rsp_valid); end
   endtask

   task automatic test_skip_idle();
      logic [NUM_REQ-1:0] seq [3];
      seq = '{4'b1000, 4'b0001, 4'b1000};
      step(4'b0001, 4'b0000, 1'b0);           // pointer now at requester 1
      for (int i = 0; i < 3; i++) begin
         step(4'b1001, 4'b0000, 1'b0);
         testsRun++; if (req_ready !== seq[i]) begin testsFailed++; $display("FAIL skip_grant i=%0d got=%b exp=%b", i, req_ready, seq[i]); end
      end
      step('0, '0, 1'b0);
   endtask

   task automatic test_random();
      logic [NUM_REQ-1:0] v, w;
      for (int i = 0; i < 300; i++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            stAddr[r] = 4'($urandom_range(0, 15));
            for (int c = 0; c < WIDTH / 32; c++) stData[r][c*32 +: 32] = $urandom();
            stMask[r] = (i % 17 == 0) ? 8'h00 : 8'($urandom());
         end
         v = 4'($urandom()); w = 4'($urandom());
         step(v, w, 1'b0);
         testsRun++; if (req_ready !== expReady) begin testsFailed++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, req_ready, expReady); end
         testsRun++; if (rsp_valid !== expRsp) begin testsFailed++; $display("FAIL rnd_rsp_valid i=%0d got=%b exp=%b", i, rsp_valid, expRsp); end
         if (expRsp != '0) begin
            testsRun++; if (rsp_data !== expRspData) begin testsFailed++; $display("FAIL rnd_rsp_data i=%0d got=%h exp=%h", i, rsp_data, expRspData); end
         end
         testsRun++; if (sram_write_en !== expWen) begin testsFailed++; $display("FAIL rnd_wen i=%0d got=%h exp=%h", i, sram_write_en, expWen); end
         if (expIsWrite) begin
            testsRun++; if (sram_write_addr !== expAddr || sram_write_data !== expWdata) begin testsFailed++; $display("FAIL rnd_wport i=%0d addr=%0d exp=%0d", i, sram_write_addr, expAddr); end
         end
         testsRun++; if (sram_read_addr !== refRaddr) begin testsFailed++; $display("FAIL rnd_raddr i=%0d got=%0d exp=%0d", i, sram_read_addr, refRaddr); end
      end
      step('0, '0, 1'b0);
      testsRun++; if (rsp_valid !== expRsp || (expRsp != '0 && rsp_data !== expRspData)) begin testsFailed++; $display("FAIL rnd_drain got=%b exp=%b", rsp_valid, expRsp); end
   endtask

   task automatic test_reinit();
      stAddr[1] = 4'($urandom_range(0, 15));
      step(4'b0010, 4'b0000, 1'b0);
      testsRun++; if (req_ready !== 4'b0010) begin testsFailed++; $display("FAIL ri_grant got=%b exp=0010", req_ready); end
      step(4'b1111, 4'b0000, 1'b1);
      testsRun++; if (req_ready !== '0) begin testsFailed++; $display("FAIL ri_start_ready got=%b exp=0", req_ready); end
      testsRun++; if (rsp_valid !== 4'b0010 || rsp_data !== expRspData) begin testsFailed++; $display("FAIL ri_inflight_rsp got=%b exp=0010", rsp_valid); end
      model_clear();
      for (int j = 0; j < NUM_ROWS; j++) begin
         @(negedge clk);
         if (j == 0) init_start = 1'b0;
         testsRun++;
         if (req_ready !== '0 || init_done !== 1'b0 || rsp_valid !== '0 || sram_write_en !== '1) begin
            testsFailed++; $display("FAIL ri_sweep j=%0d ready=%b done=%b rsp=%b wen=%h exp 0/0/0/ff", j, req_ready, init_done, rsp_valid, sram_write_en);
         end
         if (j == NUM_ROWS - 1) req_valid = '0;
      end
      @(negedge clk);
      testsRun++; if (init_done !== 1'b1) begin testsFailed++; $display("FAIL ri_done got=%b exp=1", init_done); end
      step(4'b1111, 4'b0000, 1'b0);           // pointer kept at requester 2
      testsRun++; if (req_ready !== 4'b0100) begin testsFailed++; $display("FAIL ri_rr_kept got=%b exp=0100", req_ready); end
      for (int row = 0; row <= NUM_ROWS; row++) begin
         stAddr[row % NUM_REQ] = LOG'(row);
         step((row < NUM_ROWS) ? NUM_REQ'(1 << (row % NUM_REQ)) : '0, '0, 1'b0);
         testsRun++; if (rsp_valid !== expRsp || rsp_data !== '0) begin testsFailed++; $display("FAIL ri_row row=%0d valid=%b exp=%b data=%h exp=0", row, rsp_valid, expRsp, rsp_data); end
      end
   endtask

   task automatic test_async_reset();
      stAddr[0] = 4'd7;
      step(4'b0001, 4'b0000, 1'b0);
      #2 reset = 1'b0;
      #1;
      testsRun++; if (init_done !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || sram_write_en !== '0) begin testsFailed++; $display("FAIL async_reset done=%b ready=%b rsp=%b wen=%h exp all 0", init_done, req_ready, rsp_valid, sram_write_en); end
      req_valid = '0;
   endtask

   initial begin
      for (int r = 0; r < NUM_REQ; r++) begin stAddr[r] = '0; stData[r] = '0; stMask[r] = '0; end
      model_clear(); refRr = 0; refRaddr = '0; pendData = '0;
      test_reset();
      test_roundtrip();
      test_partial_mask();
      test_round_robin();
      test_skip_idle();
      test_random();
      test_reinit();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
